// File: rtl/sobel_sequencer_pkg.sv
// Shared constants, FSM state type and the frame-border helper for the
// sobel sequencing path.
package sobel_sequencer_pkg;

   localparam int H_ACT_DEF        = 640;
   localparam int V_ACT_DEF        = 480;
   localparam int FIFO_DEPTH_DEF   = 8;
   localparam int DONE_TIMEOUT_DEF = 15;
   localparam int PIX_W            = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_PUSH      = 2'd3
   } seq_state_e;

   function automatic logic is_border(input int unsigned row, input int unsigned col,
                                      input int unsigned h_act, input int unsigned v_act);
      return (row == 32'd0) || (row == v_act - 32'd1) ||
             (col == 32'd0) || (col == h_act - 32'd1);
   endfunction

endpackage

// File: rtl/sobel_result_fifo.sv
// Show-ahead result FIFO: head is visible on rdata whenever not empty;
// a push into an empty FIFO appears one cycle later (no bypass).
module sobel_result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty = (level_q == LW'(0));
   assign full  = (level_q == LW'(DEPTH));
   assign level = level_q;
   assign rdata = mem_q[rd_ptr_q];

   // a full FIFO still accepts a write when the head leaves in the same cycle
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/sobel_sequencer.sv
// Sequences the shared sobel engine per matrix-ready event, forces zero on
// frame-border pixels and queues results for the output stage.
module sobel_sequencer
   import sobel_sequencer_pkg::*;
#(
   parameter int H_ACT        = H_ACT_DEF,
   parameter int V_ACT        = V_ACT_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
   input  logic                            I_CLK,
   input  logic                            I_RESET,
   input  logic                            I_ENABLE,
   input  logic                            I_MATRIX_READY,
   input  logic [$clog2(H_ACT)-1:0]        I_MATRIX_COL,
   input  logic [$clog2(V_ACT)-1:0]        I_MATRIX_ROW,
   output logic                            O_SOBEL_START,
   output logic [$clog2(V_ACT)-1:0]        O_SOBEL_ROW,
   output logic [$clog2(H_ACT)-1:0]        O_SOBEL_COL,
   input  logic                            I_SOBEL_DONE,
   input  logic [PIX_W-1:0]                I_SOBEL_OUT,
   output logic                            O_PIX_VALID,
   output logic [PIX_W-1:0]                O_PIX_DATA,
   input  logic                            I_PIX_READY,
   output logic [$clog2(FIFO_DEPTH):0]     O_FIFO_LEVEL,
   output logic                            O_FRAME_START,
   output logic                            O_OVERFLOW,
   output logic                            O_TIMEOUT,
   input  logic                            I_CLR_STATUS
);
   localparam int COL_W = $clog2(H_ACT);
   localparam int ROW_W = $clog2(V_ACT);
   localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

   seq_state_e        state_q, state_d;
   logic              pend_vld_q, pend_vld_d;
   logic [ROW_W-1:0]  pend_row_q, pend_row_d;
   logic [COL_W-1:0]  pend_col_q, pend_col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [PIX_W-1:0]  data_q, data_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              start_q, start_d;
   logic              frame_q, frame_d;
   logic              ovf_q, ovf_d;
   logic              tmo_q, tmo_d;
   logic              ovf_set_s, tmo_set_s;
   logic              ev_s, src_vld_s;
   logic [ROW_W-1:0]  src_row_s;
   logic [COL_W-1:0]  src_col_s;
   logic              fifo_push_s, fifo_full_s, fifo_empty_s, push_ok_s;

   assign ev_s        = I_MATRIX_READY & I_ENABLE;
   assign src_vld_s   = pend_vld_q | ev_s;
   assign src_row_s   = pend_vld_q ? pend_row_q : I_MATRIX_ROW;
   assign src_col_s   = pend_vld_q ? pend_col_q : I_MATRIX_COL;
   assign fifo_push_s = (state_q == ST_PUSH);
   assign push_ok_s   = ~fifo_full_s | I_PIX_READY;

   // next-state, pending slot, status flags
   always_comb begin
      state_d    = state_q;
      pend_vld_d = pend_vld_q;
      pend_row_d = pend_row_q;
      pend_col_d = pend_col_q;
      row_d      = row_q;
      col_d      = col_q;
      data_d     = data_q;
      tmo_cnt_d  = tmo_cnt_q;
      start_d    = 1'b0;
      frame_d    = 1'b0;
      ovf_set_s  = 1'b0;
      tmo_set_s  = 1'b0;

      // in IDLE a held entry is consumed; a simultaneous new event takes its place
      if (state_q == ST_IDLE) begin
         pend_vld_d = pend_vld_q & ev_s;
         if (pend_vld_q & ev_s) begin
            pend_row_d = I_MATRIX_ROW;
            pend_col_d = I_MATRIX_COL;
         end else begin
            pend_row_d = pend_row_q;
            pend_col_d = pend_col_q;
         end
      end else if (ev_s) begin
         if (pend_vld_q) begin
            ovf_set_s = 1'b1;
         end else begin
            pend_vld_d = 1'b1;
            pend_row_d = I_MATRIX_ROW;
            pend_col_d = I_MATRIX_COL;
         end
      end else begin
         pend_vld_d = pend_vld_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (src_vld_s) begin
               row_d   = src_row_s;
               col_d   = src_col_s;
               frame_d = (src_row_s == '0) && (src_col_s == '0);
               if (is_border(32'(src_row_s), 32'(src_col_s), 32'(H_ACT), 32'(V_ACT))) begin
                  data_d  = '0;
                  state_d = ST_PUSH;
               end else begin
                  start_d = 1'b1;
                  state_d = ST_LAUNCH;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (I_SOBEL_DONE) begin
               data_d  = I_SOBEL_OUT;
               state_d = ST_PUSH;
            end else if (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1)) begin
               data_d    = '0;
               tmo_set_s = 1'b1;
               state_d   = ST_PUSH;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         ST_PUSH: begin
            if (push_ok_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_PUSH;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ovf_d = ovf_set_s | (ovf_q & ~I_CLR_STATUS);
      tmo_d = tmo_set_s | (tmo_q & ~I_CLR_STATUS);
   end

   // state and output registers
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q    <= ST_IDLE;
         pend_vld_q <= 1'b0;
         pend_row_q <= '0;
         pend_col_q <= '0;
         row_q      <= '0;
         col_q      <= '0;
         data_q     <= '0;
         tmo_cnt_q  <= '0;
         start_q    <= 1'b0;
         frame_q    <= 1'b0;
         ovf_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         pend_row_q <= pend_row_d;
         pend_col_q <= pend_col_d;
         row_q      <= row_d;
         col_q      <= col_d;
         data_q     <= data_d;
         tmo_cnt_q  <= tmo_cnt_d;
         start_q    <= start_d;
         frame_q    <= frame_d;
         ovf_q      <= ovf_d;
         tmo_q      <= tmo_d;
      end
   end

   sobel_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk   (I_CLK),
      .rst   (I_RESET),
      .push  (fifo_push_s),
      .pop   (I_PIX_READY),
      .wdata (data_q),
      .rdata (O_PIX_DATA),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (O_FIFO_LEVEL)
   );

   assign O_PIX_VALID   = ~fifo_empty_s;
   assign O_SOBEL_START = start_q;
   assign O_SOBEL_ROW   = row_q;
   assign O_SOBEL_COL   = col_q;
   assign O_FRAME_START = frame_q;
   assign O_OVERFLOW    = ovf_q;
   assign O_TIMEOUT     = tmo_q;

endmodule

// File: tb/tb_sobel_sequencer.sv
// Directed latency/boundary checks followed by a randomized run scored
// against an in-order transaction model of the sequencer.
module tb_sobel_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       en, mready, sdone, pready, clr;
   logic [9:0] mcol;
   logic [8:0] mrow;
   logic [7:0] sout;
   logic       sstart, pvalid, fstart, ovf, tmo;
   logic [8:0] srow;
   logic [9:0] scol;
   logic [7:0] pdata;
   logic [3:0] level;

   int n_chk = 0;
   int n_bad = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  eng_q[$];
   logic [18:0] coord_q[$];
   int          eng_cnt;
   logic [7:0]  eng_data;

   always #5 clk = ~clk;

   sobel_sequencer dut (
      .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_MATRIX_READY(mready),
      .I_MATRIX_COL(mcol), .I_MATRIX_ROW(mrow), .O_SOBEL_START(sstart),
      .O_SOBEL_ROW(srow), .O_SOBEL_COL(scol), .I_SOBEL_DONE(sdone),
      .I_SOBEL_OUT(sout), .O_PIX_VALID(pvalid), .O_PIX_DATA(pdata),
      .I_PIX_READY(pready), .O_FIFO_LEVEL(level), .O_FRAME_START(fstart),
      .O_OVERFLOW(ovf), .O_TIMEOUT(tmo), .I_CLR_STATUS(clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ev(input logic [8:0] r, input logic [9:0] c);
      mrow = r; mcol = c; mready = 1'b1; en = 1'b1;
   endtask

   task automatic send_ev(input logic [8:0] r, input logic [9:0] c);
      drive_ev(r, c);
      step();
      mready = 1'b0;
   endtask

   task automatic wait_start(input logic [8:0] r, input logic [9:0] c, input string tag);
      int n = 0;
      while (!sstart && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_start"}, 32'(sstart), 32'd1);
      chk({tag, "_row"}, 32'(srow), 32'(r));
      chk({tag, "_col"}, 32'(scol), 32'(c));
   endtask

   task automatic run_engine(input logic [7:0] d);
      step();
      sdone = 1'b1; sout = d;
      step();
      sdone = 1'b0;
   endtask

   task automatic pop_exp(input logic [7:0] d, input string tag);
      int n = 0;
      while (!pvalid && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 32'(pvalid), 32'd1);
      chk({tag, "_data"}, 32'(pdata), 32'(d));
      pready = 1'b1;
      step();
      pready = 1'b0;
   endtask

   task automatic border_test(input logic [8:0] r, input logic [9:0] c, input logic fs, input string tag);
      send_ev(r, c);
      chk({tag, "_nostart"}, 32'(sstart), 32'd0);
      chk({tag, "_fs"}, 32'(fstart), 32'(fs));
      step();
      chk({tag, "_valid"}, 32'(pvalid), 32'd1);
      chk({tag, "_data"}, 32'(pdata), 32'd0);
      chk({tag, "_fs_off"}, 32'(fstart), 32'd0);
      pready = 1'b1;
      step();
      pready = 1'b0;
      chk({tag, "_drained"}, 32'(level), 32'd0);
   endtask

   initial begin
      int gap, ev_left, cyc, k;
      logic pr, ben;
      logic [8:0] rr;
      logic [9:0] rc;
      logic [7:0] v;
      logic [18:0] co;

      rst = 1'b1; en = 1'b0; mready = 1'b0; mrow = '0; mcol = '0;
      sdone = 1'b0; sout = '0; pready = 1'b0; clr = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_start", 32'(sstart), 32'd0);
      chk("rst_valid", 32'(pvalid), 32'd0);
      chk("rst_data", 32'(pdata), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_flags", 32'({ovf, tmo, fstart}), 32'd0);
      chk("rst_coords", 32'({srow, scol}), 32'd0);

      // 1: interior pixel, DONE four cycles after START
      send_ev(9'd5, 10'd7);
      chk("t1_start", 32'(sstart), 32'd1);
      chk("t1_row", 32'(srow), 32'd5);
      chk("t1_col", 32'(scol), 32'd7);
      step();
      chk("t1_start_pulse", 32'(sstart), 32'd0);
      step(); step(); step();
      sdone = 1'b1; sout = 8'hA5;
      step();
      sdone = 1'b0;
      chk("t1_not_yet", 32'(pvalid), 32'd0);
      step();
      chk("t1_valid", 32'(pvalid), 32'd1);
      chk("t1_data", 32'(pdata), 32'hA5);
      chk("t1_level1", 32'(level), 32'd1);
      pready = 1'b1;
      step();
      pready = 1'b0;
      chk("t1_level0", 32'(level), 32'd0);

      // 2: border pixels
      border_test(9'd0, 10'd0, 1'b1, "t2_00");
      border_test(9'd479, 10'd3, 1'b0, "t2_479_3");
      border_test(9'd10, 10'd639, 1'b0, "t2_10_639");

      // 3: pending slot and overflow
      drive_ev(9'd20, 10'd30);
      step();
      chk("t3_startA", 32'(sstart), 32'd1);
      drive_ev(9'd21, 10'd31);
      step();
      chk("t3_no_ovf", 32'(ovf), 32'd0);
      drive_ev(9'd22, 10'd32);
      sdone = 1'b1; sout = 8'h11;
      step();
      mready = 1'b0; sdone = 1'b0;
      chk("t3_ovf", 32'(ovf), 32'd1);
      wait_start(9'd21, 10'd31, "t3_B");
      run_engine(8'h22);
      pop_exp(8'h11, "t3_popA");
      pop_exp(8'h22, "t3_popB");
      step(); step(); step();
      chk("t3_no_third", 32'(level), 32'd0);
      chk("t3_no_restart", 32'(sstart), 32'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t3_clr", 32'(ovf), 32'd0);

      // 4: engine never answers
      send_ev(9'd100, 10'd200);
      wait_start(9'd100, 10'd200, "t4");
      for (int i = 0; i < 15; i++) step();
      chk("t4_tmo_early", 32'(tmo), 32'd0);
      step();
      chk("t4_tmo", 32'(tmo), 32'd1);
      chk("t4_not_yet", 32'(pvalid), 32'd0);
      step();
      chk("t4_valid", 32'(pvalid), 32'd1);
      chk("t4_data", 32'(pdata), 32'd0);
      pop_exp(8'h00, "t4_pop");
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t4_clr", 32'(tmo), 32'd0);

      // 5: consumer stalled until nine results exist
      for (int i = 0; i < 9; i++) begin
         send_ev(9'd50, 10'(60 + i));
         wait_start(9'd50, 10'(60 + i), "t5_ev");
         run_engine(8'(8'h31 + i));
         step(); step();
      end
      step(); step();
      chk("t5_full", 32'(level), 32'd8);
      chk("t5_head", 32'(pdata), 32'h31);
      pready = 1'b1;
      step();
      pready = 1'b0;
      chk("t5_still_full", 32'(level), 32'd8);
      chk("t5_head2", 32'(pdata), 32'h32);
      step(); step();
      chk("t5_no_more", 32'(level), 32'd8);
      for (int i = 1; i < 9; i++) pop_exp(8'(8'h31 + i), "t5_drain");
      chk("t5_empty", 32'(level), 32'd0);

      // 6: reset during WAIT_DONE
      border_test(9'd0, 10'd5, 1'b0, "t6_pre");
      send_ev(9'd0, 10'd9);
      send_ev(9'd200, 10'd300);
      wait_start(9'd200, 10'd300, "t6");
      step();
      rst = 1'b1;
      #1;
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_valid", 32'(pvalid), 32'd0);
      chk("t6_coords", 32'({srow, scol}), 32'd0);
      chk("t6_outs", 32'({sstart, fstart, ovf, tmo, pdata}), 32'd0);
      step(); step();
      rst = 1'b0;
      sdone = 1'b1; sout = 8'h77;
      step();
      sdone = 1'b0;
      step(); step();
      chk("t6_late_done", 32'(level), 32'd0);
      chk("t6_late_start", 32'(sstart), 32'd0);

      // randomized run scored against an in-order result model
      gap = 3; ev_left = 60; cyc = 0; eng_cnt = 0; eng_data = '0;
      while ((ev_left > 0 || exp_q.size() > 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         mready = 1'b0;
         sdone = 1'b0;
         pr = ($urandom_range(0, 1) == 1);
         pready = pr;
         if (pvalid && pr) begin
            if (exp_q.size() == 0) chk("rnd_extra", 32'd1, 32'd0);
            else chk("rnd_data", 32'(pdata), 32'(exp_q.pop_front()));
         end
         if (sstart) begin
            if (coord_q.size() == 0) begin
               chk("rnd_spurious_start", 32'd1, 32'd0);
            end else begin
               chk("rnd_coord", 32'({srow, scol}), 32'(coord_q.pop_front()));
               eng_data = eng_q.pop_front();
               eng_cnt = $urandom_range(1, 7);
            end
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               sdone = 1'b1;
               sout = eng_data;
            end
         end
         if (gap > 0) begin
            gap--;
         end else if (ev_left > 0 && exp_q.size() <= 4) begin
            k = $urandom_range(0, 7);
            rr = 9'($urandom_range(1, 478));
            rc = 10'($urandom_range(1, 638));
            if (k == 0) rr = 9'd0;
            if (k == 1) rr = 9'd479;
            if (k == 2) rc = 10'd0;
            if (k == 3) rc = 10'd639;
            ben = ($urandom_range(0, 7) != 0);
            mrow = rr; mcol = rc; en = ben; mready = 1'b1;
            if (ben) begin
               if (rr == 9'd0 || rr == 9'd479 || rc == 10'd0 || rc == 10'd639) begin
                  exp_q.push_back(8'h00);
               end else begin
                  v = 8'($urandom);
                  co = {rr, rc};
                  coord_q.push_back(co);
                  eng_q.push_back(v);
                  exp_q.push_back(v);
               end
            end
            gap = $urandom_range(12, 20);
            ev_left--;
         end
      end
      pready = 1'b0;
      chk("rnd_drain", 32'(exp_q.size()), 32'd0);
      chk("rnd_starts", 32'(coord_q.size()), 32'd0);
      chk("rnd_ovf", 32'(ovf), 32'd0);
      chk("rnd_tmo", 32'(tmo), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
